// File: rtl/counter_nbit_rev.sv
`default_nettype none
// ============================================================================
// counter_nbit_rev : reversible, loadable N-bit modulo counter, cascadable rc
// Revision 1.0
// ============================================================================
module counter_nbit_rev #(
   parameter int               WIDTH    = 32,
   parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
   parameter bit               SATURATE = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] d_i,
   input  logic             en_i,
   input  logic             dir_i,
   input  logic             ovf_clr_i,
   output logic [WIDTH-1:0] q_o,
   output logic             rc_o,
   output logic             ovf_o
);

   localparam logic [WIDTH-1:0] c_ZERO = '0;
   localparam logic [WIDTH-1:0] c_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] q_q, q_d;
   logic             ovf_q, ovf_d;

   logic             w_at_max;
   logic             w_at_zero;
   logic             w_terminal;
   logic [WIDTH-1:0] w_up_term;
   logic [WIDTH-1:0] w_dn_term;
   logic [WIDTH-1:0] w_load_val;

   assign w_at_max   = (q_q == MAX_VAL);
   assign w_at_zero  = (q_q == c_ZERO);
   assign w_terminal = dir_i ? w_at_max : w_at_zero;
   assign w_load_val = (d_i > MAX_VAL) ? MAX_VAL : d_i;

   // Value taken at the terminal count: hold in saturate mode, wrap otherwise.
   generate
      if (SATURATE) begin : g_saturate
         assign w_up_term = MAX_VAL;
         assign w_dn_term = c_ZERO;
      end else begin : g_wrap
         assign w_up_term = c_ZERO;
         assign w_dn_term = MAX_VAL;
      end
   endgenerate

   always_comb begin
      q_d   = q_q;
      ovf_d = ovf_q;
      if (clr_i) begin
         q_d   = c_ZERO;
         ovf_d = 1'b0;
      end else begin
         if (ovf_clr_i) begin
            ovf_d = 1'b0;
         end
         if (load_i) begin
            q_d = w_load_val;
         end else if (en_i) begin
            // A terminal event overrides a same-edge ovf_clr.
            if (w_terminal) begin
               ovf_d = 1'b1;
               q_d   = dir_i ? w_up_term : w_dn_term;
            end else begin
               q_d   = dir_i ? (q_q + c_ONE) : (q_q - c_ONE);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_q   <= c_ZERO;
         ovf_q <= 1'b0;
      end else begin
         q_q   <= q_d;
         ovf_q <= ovf_d;
      end
   end

   assign q_o   = q_q;
   assign ovf_o = ovf_q;
   assign rc_o  = en_i & ~clr_i & ~load_i & w_terminal;

endmodule
`default_nettype wire
